// File: rtl/brick_operand_slicer_if.sv
// Handshake bundle for the operand slicer: operand-pair input channel and
// 2-bit chunk-pair beat output channel toward the bit_brick multiplier.
interface brick_operand_slicer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] act;
  logic [7:0] wgt;
  logic       act_signed;
  logic       wgt_signed;
  logic [1:0] prec;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_x;
  logic [1:0] out_y;
  logic       out_sx;
  logic       out_sy;
  logic [3:0] out_shift;
  logic       out_last;
  logic       out_empty;

  modport master (
    output in_valid, act, wgt, act_signed, wgt_signed, prec, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_sx, out_sy, out_shift,
           out_last, out_empty
  );

  modport slave (
    input  in_valid, act, wgt, act_signed, wgt_signed, prec, out_ready,
    output in_ready, out_valid, out_x, out_y, out_sx, out_sy, out_shift,
           out_last, out_empty
  );
endinterface

// File: rtl/brick_operand_slicer.sv
// Splits an act/wgt pair into 2-bit chunk pairs and issues them one per beat,
// weight chunk outer / activation chunk inner, skipping all-zero weight chunks.
module brick_operand_slicer #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  brick_operand_slicer_if.slave  bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t     state, state_nxt;
  logic [7:0] act_q, wgt_q;
  logic       asg_q, wsg_q, empty_q;
  logic [1:0] nmax_q, i_q, j_q;
  logic [3:0] wmask_q;

  logic [1:0] nmax_in, jfirst_in, jnext;
  logic [3:0] wmask_in;
  logic [2:0] chunk_sum;
  logic       more, last, issuing, accept, fire;

  assign issuing = (state == ISSUE);
  assign accept  = bus.in_valid && bus.in_ready;
  assign fire    = issuing && bus.out_ready;

  // Decode the offered operation: highest chunk index, weight-chunk mask, first j.
  always_comb begin : in_decode
    nmax_in   = (bus.prec == 2'b00) ? 2'd0 : (bus.prec == 2'b01) ? 2'd1 : 2'd3;
    wmask_in  = '0;
    jfirst_in = 2'd0;
    for (int k = 0; k < 4; k++)
      if (k <= int'(nmax_in))
        wmask_in[k] = !SKIP_ZERO || (bus.wgt[2*k +: 2] != 2'b00);
    for (int k = 3; k >= 0; k--)
      if (wmask_in[k]) jfirst_in = 2'(k);
  end

  always_comb begin : next_weight_chunk
    more  = 1'b0;
    jnext = j_q;
    for (int k = 3; k >= 0; k--)
      if (wmask_q[k] && (2'(k) > j_q)) begin
        more  = 1'b1;
        jnext = 2'(k);
      end
  end

  assign last = empty_q || ((i_q == nmax_q) && !more);

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (fire && last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new operation is taken either from IDLE or on the final beat's handshake,
  // so consecutive operations issue with no bubble between them.
  always_ff @(posedge clk or posedge rst) begin : operand_regs
    if (rst) begin
      act_q   <= '0;
      wgt_q   <= '0;
      asg_q   <= 1'b0;
      wsg_q   <= 1'b0;
      empty_q <= 1'b0;
      nmax_q  <= '0;
      wmask_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else if (accept) begin
      act_q   <= bus.act;
      wgt_q   <= bus.wgt;
      asg_q   <= bus.act_signed;
      wsg_q   <= bus.wgt_signed;
      empty_q <= (wmask_in == 4'b0000);
      nmax_q  <= nmax_in;
      wmask_q <= wmask_in;
      i_q     <= 2'd0;
      j_q     <= jfirst_in;
    end else if (fire && !last) begin
      if (i_q == nmax_q) begin
        i_q <= 2'd0;
        j_q <= jnext;
      end else begin
        i_q <= i_q + 2'd1;
      end
    end
  end

  assign chunk_sum = {1'b0, i_q} + {1'b0, j_q};

  always_comb begin : outputs
    bus.out_valid = issuing;
    bus.in_ready  = !rst && (!issuing || (bus.out_ready && last));
    bus.out_x     = empty_q ? 2'b00 : act_q[{i_q, 1'b0} +: 2];
    bus.out_y     = empty_q ? 2'b00 : wgt_q[{j_q, 1'b0} +: 2];
    bus.out_sx    = asg_q && (i_q == nmax_q) && !empty_q;
    bus.out_sy    = wsg_q && (j_q == nmax_q) && !empty_q;
    bus.out_shift = {chunk_sum, 1'b0};
    bus.out_last  = issuing && last;
    bus.out_empty = empty_q;
  end

endmodule

// File: tb/tb_brick_operand_slicer.sv
// Randomised and directed checks of brick_operand_slicer against a loop-based
// chunk-pair model and exact-product reconstruction from observed beats.
module tb_brick_operand_slicer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  brick_operand_slicer_if bus();
  brick_operand_slicer_if bus0();

  brick_operand_slicer #(.SKIP_ZERO(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  brick_operand_slicer #(.SKIP_ZERO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct packed {
    logic [1:0] x, y;
    logic       sx, sy;
    logic [3:0] shift;
    logic       last, empty;
  } beat_t;

  typedef struct packed {
    logic [7:0] a, w;
    logic       sa, sw;
    logic [1:0] p;
  } op_t;

  int    vectors = 0;
  int    miscompares = 0;
  op_t   ops[$];
  beat_t expq[$];
  beat_t obsq[$];
  int    obs_cyc[$];
  int    acc_cyc[$];
  int    stall_breaks;
  bit    timed_out;

  function automatic op_t mk_op(input logic [7:0] a, input logic [7:0] w,
                                input logic sa, input logic sw, input logic [1:0] p);
    op_t o;
    o.a = a; o.w = w; o.sa = sa; o.sw = sw; o.p = p;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a  = 8'($urandom);
    o.sa = 1'($urandom);
    o.sw = 1'($urandom);
    o.p  = 2'($urandom);
    for (int k = 0; k < 4; k++)
      o.w[2*k +: 2] = ($urandom_range(9) < 4) ? 2'b00 : 2'($urandom);
    return o;
  endfunction

  function automatic int opval(input logic [7:0] v, input logic s, input logic [1:0] p);
    int bits = (p == 2'b00) ? 2 : (p == 2'b01) ? 4 : 8;
    int u = int'(v) & ((1 << bits) - 1);
    if (s && u >= (1 << (bits - 1))) u -= (1 << bits);
    return u;
  endfunction

  function automatic int exact(input op_t o);
    return opval(o.a, o.sa, o.p) * opval(o.w, o.sw, o.p);
  endfunction

  function automatic int brick(input beat_t b);
    int xv = int'(b.x);
    int yv = int'(b.y);
    if (b.sx && b.x[1]) xv -= 4;
    if (b.sy && b.y[1]) yv -= 4;
    return (xv * yv) << b.shift;
  endfunction

  // Expected beat list: weight chunks outer, activation chunks inner.
  function automatic void model(input op_t o, input bit skip);
    int n = (o.p == 2'b00) ? 1 : (o.p == 2'b01) ? 2 : 4;
    int lastj = -1;
    logic [7:0] a = o.a;
    logic [7:0] w = o.w;
    beat_t b;
    for (int j = 0; j < n; j++)
      if (!skip || w[2*j +: 2] != 2'b00) lastj = j;
    if (lastj < 0) begin
      b = '0; b.last = 1'b1; b.empty = 1'b1;
      expq.push_back(b);
      return;
    end
    for (int j = 0; j < n; j++) begin
      if (skip && w[2*j +: 2] == 2'b00) continue;
      for (int i = 0; i < n; i++) begin
        b = '0;
        b.x = a[2*i +: 2];
        b.y = w[2*j +: 2];
        b.sx = o.sa && (i == n - 1);
        b.sy = o.sw && (j == n - 1);
        b.shift = 4'(2 * (i + j));
        b.last = (i == n - 1) && (j == lastj);
        expq.push_back(b);
      end
    end
  endfunction

  task automatic drive(input int which, input logic iv, input op_t o, input logic orr);
    if (which == 0) begin
      bus.in_valid = iv; bus.act = o.a; bus.wgt = o.w; bus.act_signed = o.sa;
      bus.wgt_signed = o.sw; bus.prec = o.p; bus.out_ready = orr;
    end else begin
      bus0.in_valid = iv; bus0.act = o.a; bus0.wgt = o.w; bus0.act_signed = o.sa;
      bus0.wgt_signed = o.sw; bus0.prec = o.p; bus0.out_ready = orr;
    end
  endtask

  task automatic sample(input int which, output logic ir, output logic ov, output beat_t b);
    if (which == 0) begin
      ir = bus.in_ready; ov = bus.out_valid;
      b.x = bus.out_x; b.y = bus.out_y; b.sx = bus.out_sx; b.sy = bus.out_sy;
      b.shift = bus.out_shift; b.last = bus.out_last; b.empty = bus.out_empty;
    end else begin
      ir = bus0.in_ready; ov = bus0.out_valid;
      b.x = bus0.out_x; b.y = bus0.out_y; b.sx = bus0.out_sx; b.sy = bus0.out_sy;
      b.shift = bus0.out_shift; b.last = bus0.out_last; b.empty = bus0.out_empty;
    end
  endtask

  // Feeds every op in ops[] and records handshaken beats; hold_beat >= 0 forces
  // a 3-cycle out_ready stall when that beat index is presented.
  task automatic run_ops(input int which, input int stall_pct, input int gap_pct, input int hold_beat);
    int idx = 0, done = 0, cyc = 0, hold_left = 0;
    bit held = 0, prev_stall = 0;
    logic iv, orr, ir, ov;
    beat_t b, prev_b;
    op_t o;
    obsq.delete(); obs_cyc.delete(); acc_cyc.delete();
    stall_breaks = 0; timed_out = 0; prev_b = '0;
    while (done < ops.size() && !timed_out) begin
      @(negedge clk);
      o  = (idx < ops.size()) ? ops[idx] : '0;
      iv = (idx < ops.size()) && ($urandom_range(99) >= gap_pct);
      if (!held && hold_beat >= 0 && obsq.size() == hold_beat) begin
        held = 1; hold_left = 3;
      end
      orr = (hold_left > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      if (hold_left > 0) hold_left--;
      drive(which, iv, o, orr);
      #1;
      sample(which, ir, ov, b);
      if (prev_stall && (!ov || b != prev_b)) stall_breaks++;
      prev_stall = ov && !orr;
      prev_b = b;
      if (iv && ir) begin acc_cyc.push_back(cyc); idx++; end
      if (ov && orr) begin
        obsq.push_back(b); obs_cyc.push_back(cyc);
        if (b.last) done++;
      end
      cyc++;
      if (cyc > 5000) timed_out = 1;
    end
  endtask

  task automatic test_reset();
    logic ir, ov; beat_t b;
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #1 sample(0, ir, ov, b);
    vectors++; if (ir !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 0", ir); end
    vectors++; if (ov !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", ov); end
    @(negedge clk) rst = 1'b0;
    #1 sample(0, ir, ov, b);
    vectors++; if (ir !== 1'b1) begin miscompares++; $display("[TB] FAIL release_in_ready got %b want 1", ir); end
    vectors++; if (ov !== 1'b0) begin miscompares++; $display("[TB] FAIL release_out_valid got %b want 0", ov); end
    vectors++; if (b !== beat_t'(0)) begin miscompares++; $display("[TB] FAIL release_fields got %h want 0", b); end
    sample(1, ir, ov, b);
    vectors++; if (ir !== 1'b1 || ov !== 1'b0) begin miscompares++; $display("[TB] FAIL release_noskip got rdy=%b vld=%b want 1/0", ir, ov); end
  endtask

  task automatic test_plan_vectors();
    op_t cases[4];
    int  ncnt[4];
    int  nsum[4];
    int  sum;
    cases[0] = mk_op(8'h03, 8'h05, 1'b0, 1'b0, 2'b10);
    cases[1] = mk_op(8'h03, 8'h02, 1'b1, 1'b1, 2'b00);
    cases[2] = mk_op(8'h0F, 8'h02, 1'b1, 1'b1, 2'b01);
    cases[3] = mk_op(8'h5A, 8'h00, 1'b0, 1'b0, 2'b10);
    ncnt = '{8, 1, 2, 1};
    nsum = '{15, 2, -2, 0};
    for (int c = 0; c < 4; c++) begin
      ops.delete(); ops.push_back(cases[c]);
      expq.delete(); model(cases[c], 1'b1);
      run_ops(0, 0, 0, -1);
      vectors++; if (timed_out) begin miscompares++; $display("[TB] FAIL plan%0d_timeout got %0d beats want %0d", c, obsq.size(), ncnt[c]); end
      vectors++; if (obsq.size() != ncnt[c]) begin miscompares++; $display("[TB] FAIL plan%0d_count got %0d want %0d", c, obsq.size(), ncnt[c]); end
      sum = 0;
      for (int k = 0; k < obsq.size(); k++) begin
        sum += brick(obsq[k]);
        vectors++;
        if (k >= expq.size() || obsq[k] !== expq[k]) begin
          miscompares++;
          $display("[TB] FAIL plan%0d_beat%0d got %h want %h", c, k, obsq[k], (k < expq.size()) ? expq[k] : beat_t'(0));
        end
      end
      vectors++; if (sum != nsum[c]) begin miscompares++; $display("[TB] FAIL plan%0d_sum got %0d want %0d", c, sum, nsum[c]); end
    end
  endtask

  task automatic test_no_skip();
    op_t o = mk_op(8'h5A, 8'h00, 1'b0, 1'b0, 2'b10);
    int sum = 0;
    ops.delete(); ops.push_back(o);
    expq.delete(); model(o, 1'b0);
    run_ops(1, 0, 0, -1);
    vectors++; if (timed_out || obsq.size() != 16) begin miscompares++; $display("[TB] FAIL noskip_count got %0d want 16", obsq.size()); end
    for (int k = 0; k < obsq.size(); k++) begin
      sum += brick(obsq[k]);
      vectors++;
      if (k >= expq.size() || obsq[k] !== expq[k] || obsq[k].empty !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL noskip_beat%0d got %h want %h", k, obsq[k], (k < expq.size()) ? expq[k] : beat_t'(0));
      end
    end
    vectors++; if (sum != 0) begin miscompares++; $display("[TB] FAIL noskip_sum got %0d want 0", sum); end
  endtask

  task automatic test_random();
    int opi, acc;
    for (int which = 0; which < 2; which++) begin
      ops.delete(); expq.delete();
      for (int n = 0; n < ((which == 0) ? 40 : 15); n++) begin
        ops.push_back(rand_op());
        model(ops[n], (which == 0));
      end
      run_ops(which, 30, 30, -1);
      vectors++; if (timed_out || obsq.size() != expq.size()) begin miscompares++; $display("[TB] FAIL rand%0d_count got %0d want %0d", which, obsq.size(), expq.size()); end
      vectors++; if (stall_breaks != 0) begin miscompares++; $display("[TB] FAIL rand%0d_stall_hold got %0d changes want 0", which, stall_breaks); end
      opi = 0; acc = 0;
      for (int k = 0; k < obsq.size(); k++) begin
        vectors++;
        if (k >= expq.size() || obsq[k] !== expq[k]) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_beat%0d got %h want %h", which, k, obsq[k], (k < expq.size()) ? expq[k] : beat_t'(0));
        end
        acc += brick(obsq[k]);
        if (obsq[k].last && opi < ops.size()) begin
          vectors++;
          if (acc != exact(ops[opi])) begin miscompares++; $display("[TB] FAIL rand%0d_product%0d got %0d want %0d", which, opi, acc, exact(ops[opi])); end
          opi++; acc = 0;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    op_t o = mk_op(8'hC6, 8'h9D, 1'b1, 1'b0, 2'b10);
    ops.delete(); ops.push_back(o);
    expq.delete(); model(o, 1'b1);
    run_ops(0, 0, 0, 5);
    vectors++; if (timed_out || obsq.size() != 16) begin miscompares++; $display("[TB] FAIL bp_count got %0d want 16", obsq.size()); end
    vectors++; if (stall_breaks != 0) begin miscompares++; $display("[TB] FAIL bp_hold got %0d changes want 0", stall_breaks); end
    vectors++;
    if (obsq.size() == 16 && obs_cyc[15] - obs_cyc[0] != 18) begin
      miscompares++; $display("[TB] FAIL bp_span got %0d cycles want 18", obs_cyc[15] - obs_cyc[0]);
    end
    for (int k = 0; k < obsq.size() && k < expq.size(); k++) begin
      vectors++;
      if (obsq[k] !== expq[k]) begin miscompares++; $display("[TB] FAIL bp_beat%0d got %h want %h", k, obsq[k], expq[k]); end
    end
  endtask

  task automatic test_back_to_back();
    ops.delete(); expq.delete();
    ops.push_back(mk_op(8'h03, 8'h05, 1'b0, 1'b0, 2'b10));
    ops.push_back(mk_op(8'h0F, 8'h0E, 1'b1, 1'b1, 2'b01));
    model(ops[0], 1'b1); model(ops[1], 1'b1);
    run_ops(0, 0, 0, -1);
    vectors++;
    if (timed_out || obsq.size() != expq.size() || acc_cyc.size() != 2) begin
      miscompares++; $display("[TB] FAIL b2b_count got %0d beats want %0d", obsq.size(), expq.size());
    end else begin
      vectors++; if (obs_cyc[0] != acc_cyc[0] + 1) begin miscompares++; $display("[TB] FAIL b2b_latency got %0d want %0d", obs_cyc[0], acc_cyc[0] + 1); end
      vectors++; if (acc_cyc[1] != obs_cyc[7]) begin miscompares++; $display("[TB] FAIL b2b_accept_on_last got %0d want %0d", acc_cyc[1], obs_cyc[7]); end
      vectors++; if (obs_cyc[8] != acc_cyc[1] + 1) begin miscompares++; $display("[TB] FAIL b2b_no_bubble got %0d want %0d", obs_cyc[8], acc_cyc[1] + 1); end
      for (int k = 0; k < obsq.size(); k++) begin
        vectors++;
        if (obsq[k] !== expq[k]) begin miscompares++; $display("[TB] FAIL b2b_beat%0d got %h want %h", k, obsq[k], expq[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    op_t o = mk_op(8'h03, 8'h05, 1'b0, 1'b0, 2'b10);
    logic ir, ov; beat_t b;
    expq.delete(); model(o, 1'b1);
    @(negedge clk) drive(0, 1'b1, o, 1'b1);
    @(negedge clk) drive(0, 1'b0, o, 1'b1);
    repeat (2) @(negedge clk);
    #1 sample(0, ir, ov, b);
    vectors++; if (ov !== 1'b1 || b !== expq[2]) begin miscompares++; $display("[TB] FAIL mid_beat3 got vld=%b %h want 1 %h", ov, b, expq[2]); end
    #1 rst = 1'b1;
    #1 sample(0, ir, ov, b);
    vectors++; if (ov !== 1'b0 || ir !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async got vld=%b rdy=%b want 0/0", ov, ir); end
    @(negedge clk) rst = 1'b0;
    #1 sample(0, ir, ov, b);
    vectors++; if (ov !== 1'b0 || ir !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_release got vld=%b rdy=%b want 0/1", ov, ir); end
    ops.delete(); ops.push_back(o);
    run_ops(0, 0, 0, -1);
    vectors++; if (timed_out || obsq.size() != expq.size()) begin miscompares++; $display("[TB] FAIL mid_reissue_count got %0d want %0d", obsq.size(), expq.size()); end
    for (int k = 0; k < obsq.size() && k < expq.size(); k++) begin
      vectors++;
      if (obsq[k] !== expq[k]) begin miscompares++; $display("[TB] FAIL mid_reissue_beat%0d got %h want %h", k, obsq[k], expq[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_no_skip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
